hs_unit_skid_buffer: RTL and testbench
======================================

HS_UNIT_SKID_BUFFER -- requirements
Module: hs_unit_skid_buffer

Interface
REQ-001 The block SHALL have one parameter: DATA_TYPE, default logic, the payload type carried on s_data and m_data.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have the port s_valid, input, 1 bit, indicating that upstream data is valid.
REQ-005 The block SHALL have the port s_ready, output, 1 bit, indicating that the block can accept data; it SHALL be driven directly from a flop.
REQ-006 The block SHALL have the port s_data, input, DATA_TYPE, the upstream payload.
REQ-007 The block SHALL have the port m_valid, output, 1 bit, indicating that downstream data is valid; it SHALL be driven directly from a flop.
REQ-008 The block SHALL have the port m_ready, input, 1 bit, indicating that downstream accepts data.
REQ-009 The block SHALL have the port m_data, output, DATA_TYPE, the downstream payload; it SHALL be driven directly from the main data register.
REQ-010 The block SHALL have the port level, output, 2 bits, the current occupancy (0, 1 or 2).

Function
REQ-011 A transfer SHALL occur on an interface when valid and ready are both 1 at a rising clk edge; in_xfer = s_valid & s_ready and out_xfer = m_valid & m_ready.
REQ-012 The block SHALL hold at most two entries: a main register (drives m_data) and a skid register.
REQ-013 The state machine SHALL have three states: EMPTY (level 0), ONE (level 1), FULL (level 2).
REQ-014 In EMPTY, in_xfer SHALL load main with s_data and move to ONE; otherwise the block SHALL stay in EMPTY.
REQ-015 In ONE, in_xfer together with out_xfer SHALL load main with s_data and stay in ONE.
REQ-016 In ONE, in_xfer without out_xfer SHALL load skid with s_data and move to FULL, leaving main unchanged.
REQ-017 In ONE, out_xfer without in_xfer SHALL move to EMPTY.
REQ-018 In ONE, with neither transfer, the block SHALL stay in ONE and hold all data.
REQ-019 In FULL, out_xfer SHALL copy skid into main and move to ONE; otherwise the block SHALL stay in FULL.
REQ-020 In FULL, in_xfer SHALL be impossible because s_ready is 0.
REQ-021 s_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, computed from the next state so that it is registered with no combinational path from m_ready.
REQ-022 m_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-023 Latency from in_xfer to m_valid=1 with that data SHALL be exactly 1 cycle when the block is in EMPTY.
REQ-024 Sustained throughput SHALL be 1 transfer per cycle when m_ready is held at 1.
REQ-025 Output ordering SHALL be strict FIFO; the block SHALL never drop or duplicate data.
REQ-026 While m_valid=1 and m_ready=0, m_data and m_valid SHALL remain stable.
REQ-027 When m_valid=0, m_data SHALL be don't-care.
REQ-028 The data registers (main and skid) SHALL have no reset and SHALL load only on the enables defined in REQ-014 to REQ-019.
REQ-029 The level output SHALL equal the state encoding: EMPTY=0, ONE=1, FULL=2; the value 3 SHALL never occur.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately, without waiting for a clock edge, force the state to EMPTY, m_valid=0, s_ready=0 and level=0.
REQ-031 After rst_n deasserts, s_ready SHALL rise to 1 at the first rising clk edge.
REQ-032 A reset asserted mid-operation SHALL discard all held entries; no stale data SHALL appear after reset with m_valid=1.
REQ-033 Deassertion of rst_n SHALL be synchronised externally; the block SHALL NOT contain a reset synchroniser.

Verification
REQ-034 Bench scenario, reset release: hold rst_n=0 for 3 cycles, then release -> m_valid=0 and level=0 throughout; s_ready=0 during reset and 1 one cycle after release.
REQ-035 Bench scenario, streaming: stream 0x01..0x10 with s_valid=1 and m_ready=1 -> 0x01..0x10 appear in order, one per cycle, each 1 cycle after acceptance, with level staying at 1.
REQ-036 Bench scenario, backpressure: send 0xA1 and 0xA2 in consecutive cycles with m_ready=0 -> level=2, s_ready=0, m_data=0xA1 stable; then raise m_ready -> 0xA1 then 0xA2 are delivered and level returns to 0.
REQ-037 Bench scenario, simultaneous events: in ONE holding 0x11, apply in_xfer 0x22 and out_xfer in the same cycle -> m_data=0x22 next cycle and level stays at 1.
REQ-038 Bench scenario, reset mid-operation: in FULL with 0x33/0x44, pulse rst_n low asynchronously between clock edges -> m_valid=0 immediately; after release, neither 0x33 nor 0x44 is ever output.
REQ-039 Bench scenario, random traffic: run 10,000 cycles of random s_valid and m_ready -> output matches a scoreboard FIFO exactly, with no transfer into FULL and level never equal to 3.

Source files
------------

// File: rtl/hs_unit_skid_buffer.sv
// Two-entry valid/ready skid buffer: full throughput with every handshake output
// driven from a flop, so no combinational path runs from m_ready to s_ready.
module hs_unit_skid_buffer #(
   parameter type DATA_TYPE = logic
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_valid,
   output logic       s_ready,
   input  DATA_TYPE   s_data,
   output logic       m_valid,
   input  logic       m_ready,
   output DATA_TYPE   m_data,
   output logic [1:0] level
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t   state;
   state_t   next_state;
   DATA_TYPE skid;
   logic     in_xfer;
   logic     out_xfer;
   logic     load_main_in;
   logic     load_main_skid;
   logic     load_skid;

   assign in_xfer  = s_valid & s_ready;
   assign out_xfer = m_valid & m_ready;
   assign level    = state;

   // Next occupancy and data-register load enables.
   always_comb begin
      next_state     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               load_main_in = 1'b1;
               next_state   = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_main_in = 1'b1;
            end else if (in_xfer) begin
               load_skid  = 1'b1;
               next_state = FULL;
            end else if (out_xfer) begin
               next_state = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               load_main_skid = 1'b1;
               next_state     = ONE;
            end
         end
         default: next_state = EMPTY;
      endcase
   end

   // State and handshake flops; s_ready is held low for the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         m_valid <= 1'b0;
         s_ready <= 1'b0;
      end else begin
         state   <= next_state;
         m_valid <= (next_state != EMPTY);
         s_ready <= (next_state != FULL);
      end
   end

   // Payload registers carry no reset; m_valid qualifies their contents.
   always_ff @(posedge clk) begin
      if (load_main_in) begin
         m_data <= s_data;
      end else if (load_main_skid) begin
         m_data <= skid;
      end
      if (load_skid) begin
         skid <= s_data;
      end
   end

endmodule

// File: tb/tb_hs_unit_skid_buffer.sv
// Bench for hs_unit_skid_buffer: directed scenarios plus random traffic,
// checked against a queue-based occupancy/ordering model.
module tb_hs_unit_skid_buffer;

   logic       clk;
   logic       rst_n;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [1:0] level;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   // Model: queue of accepted-but-undelivered items, plus "one edge seen since reset".
   logic [7:0] q[$];
   bit         rdy_ok = 1'b0;

   hs_unit_skid_buffer #(.DATA_TYPE(logic [7:0])) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .level   (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic exp_valid();
      return q.size() != 0;
   endfunction

   function automatic logic exp_ready();
      return rdy_ok && (q.size() < 2);
   endfunction

   function automatic logic [1:0] exp_level();
      return 2'(q.size());
   endfunction

   function automatic logic [7:0] exp_data();
      return (q.size() != 0) ? q[0] : 8'h00;
   endfunction

   // Apply one clock edge to the model with the currently driven inputs.
   task automatic advance();
      bit in_x;
      bit out_x;
      in_x  = s_valid && exp_ready();
      out_x = m_ready && exp_valid();
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(s_data);
      rdy_ok = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      rdy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n   = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      s_data  = 8'h00;
      #2 rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if ({m_valid, s_ready, level} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d: got v=%b r=%b l=%0d, want v=0 r=0 l=0",
                     i, m_valid, s_ready, level);
         end
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if ({m_valid, s_ready, level} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_release: got v=%b r=%b l=%0d, want v=0 r=0 l=0",
                  m_valid, s_ready, level);
      end
      advance();
      vectors++;
      if ({m_valid, s_ready, level} !== 4'b0100) begin
         miscompares++;
         $display("FAIL reset_first_edge: got v=%b r=%b l=%0d, want v=0 r=1 l=0",
                  m_valid, s_ready, level);
      end
   endtask

   task automatic test_stream();
      m_ready = 1'b1;
      s_valid = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         s_data = 8'(i);
         if (i > 1) begin
            vectors++;
            if ({m_valid, s_ready, level} !== 4'b1101 || m_data !== 8'(i - 1)) begin
               miscompares++;
               $display("FAIL stream i=%0d: got v=%b r=%b l=%0d d=%h, want v=1 r=1 l=1 d=%h",
                        i, m_valid, s_ready, level, m_data, 8'(i - 1));
            end
         end
         advance();
      end
      s_valid = 1'b0;
      vectors++;
      if ({m_valid, level} !== 3'b101 || m_data !== 8'h10) begin
         miscompares++;
         $display("FAIL stream_last: got v=%b l=%0d d=%h, want v=1 l=1 d=10",
                  m_valid, level, m_data);
      end
      advance();
      vectors++;
      if ({m_valid, s_ready, level} !== {exp_valid(), exp_ready(), exp_level()}) begin
         miscompares++;
         $display("FAIL stream_drain: got v=%b r=%b l=%0d, want v=%b r=%b l=%0d",
                  m_valid, s_ready, level, exp_valid(), exp_ready(), exp_level());
      end
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hA1;
      advance();
      s_data  = 8'hA2;
      advance();
      s_valid = 1'b0;
      s_data  = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({m_valid, s_ready, level} !== 4'b1010 || m_data !== 8'hA1) begin
            miscompares++;
            $display("FAIL bp_hold cyc%0d: got v=%b r=%b l=%0d d=%h, want v=1 r=0 l=2 d=a1",
                     i, m_valid, s_ready, level, m_data);
         end
         advance();
      end
      m_ready = 1'b1;
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 8'hA1) begin
         miscompares++;
         $display("FAIL bp_first: got v=%b d=%h, want v=1 d=a1", m_valid, m_data);
      end
      advance();
      vectors++;
      if ({m_valid, level} !== 3'b101 || m_data !== 8'hA2) begin
         miscompares++;
         $display("FAIL bp_second: got v=%b l=%0d d=%h, want v=1 l=1 d=a2", m_valid, level, m_data);
      end
      advance();
      vectors++;
      if ({m_valid, s_ready, level} !== 4'b0100) begin
         miscompares++;
         $display("FAIL bp_empty: got v=%b r=%b l=%0d, want v=0 r=1 l=0", m_valid, s_ready, level);
      end
   endtask

   task automatic test_simultaneous();
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h11;
      advance();
      vectors++;
      if ({m_valid, level} !== 3'b101 || m_data !== 8'h11) begin
         miscompares++;
         $display("FAIL simul_one: got v=%b l=%0d d=%h, want v=1 l=1 d=11", m_valid, level, m_data);
      end
      s_data  = 8'h22;
      m_ready = 1'b1;
      advance();
      s_valid = 1'b0;
      vectors++;
      if ({m_valid, s_ready, level} !== 4'b1101 || m_data !== 8'h22) begin
         miscompares++;
         $display("FAIL simul_swap: got v=%b r=%b l=%0d d=%h, want v=1 r=1 l=1 d=22",
                  m_valid, s_ready, level, m_data);
      end
      advance();
      vectors++;
      if (level !== 2'd0 || m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_drain: got v=%b l=%0d, want v=0 l=0", m_valid, level);
      end
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h33;
      advance();
      s_data  = 8'h44;
      advance();
      s_valid = 1'b0;
      vectors++;
      if (level !== 2'd2 || m_data !== 8'h33) begin
         miscompares++;
         $display("FAIL rmid_full: got l=%0d d=%h, want l=2 d=33", level, m_data);
      end
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if ({m_valid, s_ready, level} !== 4'b0000) begin
         miscompares++;
         $display("FAIL rmid_async: got v=%b r=%b l=%0d, want v=0 r=0 l=0", m_valid, s_ready, level);
      end
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         advance();
         vectors++;
         if (m_valid !== 1'b0 || level !== 2'd0) begin
            miscompares++;
            $display("FAIL rmid_stale cyc%0d: got v=%b l=%0d d=%h, want v=0 l=0",
                     i, m_valid, level, m_data);
         end
      end
      s_valid = 1'b1;
      s_data  = 8'h55;
      advance();
      s_valid = 1'b0;
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 8'h55) begin
         miscompares++;
         $display("FAIL rmid_after: got v=%b d=%h, want v=1 d=55", m_valid, m_data);
      end
      advance();
   endtask

   task automatic test_random();
      for (int i = 0; i < 10000; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         m_ready = 1'($urandom_range(0, 1));
         s_data  = 8'($urandom);
         vectors++;
         if ({m_valid, s_ready, level} !== {exp_valid(), exp_ready(), exp_level()}
             || level === 2'd3) begin
            miscompares++;
            $display("FAIL rand_ctl cyc%0d: got v=%b r=%b l=%0d, want v=%b r=%b l=%0d",
                     i, m_valid, s_ready, level, exp_valid(), exp_ready(), exp_level());
         end
         if (exp_valid()) begin
            vectors++;
            if (m_data !== exp_data()) begin
               miscompares++;
               $display("FAIL rand_data cyc%0d: got %h, want %h", i, m_data, exp_data());
            end
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
